// File: rtl/minimicro_mc_pkg.sv
// minimicro_mc shared types: opcodes, branch conds, FSM states, ALU ops.
// Field positions of the 16-bit instruction word live here too.
package minimicro_mc_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_LD   = 4'h6,
    OP_ST   = 4'h7,
    OP_B    = 4'h8,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [3:0] {
    BR_AL = 4'h0,
    BR_EQ = 4'h1,
    BR_NE = 4'h2,
    BR_MI = 4'h3,
    BR_PL = 4'h4,
    BR_CS = 4'h5,
    BR_CC = 4'h6
  } branch_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR
  } alu_op_t;

  localparam int OP_LSB  = 12;
  localparam int HI_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RD_LSB  = 0;
  localparam int TGT_W   = 8;

  // Ops that write a register from the ALU and update flags.
  function automatic logic is_alu_op(logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR) ||
           (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/minimicro_mc_alu.sv
// mm_alu: combinational ALU with zero/negative flags (carry optional).
// Ports: op_i, a_i, b_i -> res_o, z_o, n_o [, c_o with MINIMICRO_MC_CARRY_EN].
module mm_alu
  import minimicro_mc_pkg::*;
#(
  parameter int W = 16
) (
  input  alu_op_t      op_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] res_o,
  output logic         z_o,
`ifdef MINIMICRO_MC_CARRY_EN
  output logic         c_o,
`endif
  output logic         n_o
);

`ifdef MINIMICRO_MC_CARRY_EN
  logic [W:0] sum;
  logic [W:0] dif;

  // c on SUB is "no borrow": a + ~b + 1 carries out iff a >= b.
  always_comb begin
    sum = {1'b0, a_i} + {1'b0, b_i};
    dif = {1'b0, a_i} + {1'b0, ~b_i} + {{W{1'b0}}, 1'b1};
    res_o = '0;
    c_o = 1'b0;
    unique case (op_i)
      ALU_ADD: {c_o, res_o} = sum;
      ALU_SUB: {c_o, res_o} = dif;
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      default: res_o = '0;
    endcase
  end
`else
  always_comb begin
    res_o = '0;
    unique case (op_i)
      ALU_ADD: res_o = a_i + b_i;
      ALU_SUB: res_o = a_i - b_i;
      ALU_AND: res_o = a_i & b_i;
      ALU_OR:  res_o = a_i | b_i;
      default: res_o = '0;
    endcase
  end
`endif

  assign z_o = (res_o == '0);
  assign n_o = res_o[W-1];

endmodule

// File: rtl/minimicro_mc.sv
// minimicro_mc: multi-cycle 16-bit ISA core with req/ack IMEM/DMEM ports.
// Ports: clk, rst_n (sync, low); imem_req/addr/ack/rdata; dmem_req/we/
//  addr/wdata/ack/rdata; halted, pc. Macro MINIMICRO_MC_CARRY_EN adds c.
module minimicro_mc
  import minimicro_mc_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int NREGS       = 16,
  parameter int PC_WIDTH    = 8,
  parameter int DADDR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [15:0]            imem_rdata,
  output logic                   dmem_req,
  output logic                   dmem_we,
  output logic [DADDR_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]  dmem_wdata,
  input  logic                   dmem_ack,
  input  logic [DATA_WIDTH-1:0]  dmem_rdata,
  output logic                   halted,
  output logic [PC_WIDTH-1:0]    pc
);

  localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0] ir_q;
  logic [DATA_WIDTH-1:0] rf_q [NREGS];
  logic [DATA_WIDTH-1:0] a_q, b_q, wb_q;
  logic z_q, n_q;
  logic imem_req_q, dmem_req_q, dmem_we_q;
  logic [DADDR_WIDTH-1:0] daddr_q;
  logic [DATA_WIDTH-1:0] dwdata_q;

  logic [3:0] op, f_hi, f_rs1, f_rd, rb_idx;
  logic [TGT_W-1:0] tgt;
  logic op_alu, op_mem, op_halt, taken;
  logic fetch_done, mem_done, rd_ok;
  logic [DATA_WIDTH-1:0] ra_val, rb_val;
  logic [DATA_WIDTH-1:0] alu_b, alu_res;
  logic [DADDR_WIDTH-1:0] ea;
  logic alu_z, alu_n;
  alu_op_t alu_op;

  assign op    = ir_q[OP_LSB+:4];
  assign f_hi  = ir_q[HI_LSB+:4];
  assign f_rs1 = ir_q[RS1_LSB+:4];
  assign f_rd  = ir_q[RD_LSB+:4];
  assign tgt   = ir_q[TGT_W-1:0];

  assign op_alu  = is_alu_op(op);
  assign op_mem  = (op == OP_LD) || (op == OP_ST);
  assign op_halt = (op == OP_HALT);

  // Acks only count while our own request is up.
  assign fetch_done = (state_q == S_FETCH) && imem_req_q && imem_ack;
  assign mem_done   = (state_q == S_MEM) && dmem_req_q && dmem_ack;

  // ST reads its data register through the rd field.
  assign rb_idx = (op == OP_ST) ? f_rd : f_hi;
  assign rd_ok  = 32'(f_rd) < NREGS;

  always_comb begin
    ra_val = '0;
    rb_val = '0;
    if (32'(f_rs1) < NREGS) ra_val = rf_q[f_rs1[RI_W-1:0]];
    if (32'(rb_idx) < NREGS) rb_val = rf_q[rb_idx[RI_W-1:0]];
  end

  always_comb begin
    alu_op = ALU_ADD;
    unique case (1'b1)
      op == OP_SUB: alu_op = ALU_SUB;
      op == OP_AND: alu_op = ALU_AND;
      op == OP_OR:  alu_op = ALU_OR;
      default:      alu_op = ALU_ADD;
    endcase
  end

  assign alu_b = (op == OP_ADDI) ? DATA_WIDTH'(f_hi) : b_q;
  assign ea = a_q[DADDR_WIDTH-1:0] + DADDR_WIDTH'(f_hi);

`ifdef MINIMICRO_MC_CARRY_EN
  logic c_q, alu_c;
`endif

  mm_alu #(.W(DATA_WIDTH)) u_alu (
    .op_i  (alu_op),
    .a_i   (a_q),
    .b_i   (alu_b),
    .res_o (alu_res),
    .z_o   (alu_z),
`ifdef MINIMICRO_MC_CARRY_EN
    .c_o   (alu_c),
`endif
    .n_o   (alu_n)
  );

  always_comb begin
    taken = 1'b0;
    if (op == OP_B) begin
      unique case (f_hi)
        BR_AL:   taken = 1'b1;
        BR_EQ:   taken = z_q;
        BR_NE:   taken = !z_q;
        BR_MI:   taken = n_q;
        BR_PL:   taken = !n_q;
`ifdef MINIMICRO_MC_CARRY_EN
        BR_CS:   taken = c_q;
        BR_CC:   taken = !c_q;
`endif
        default: taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    unique case (state_q)
      S_FETCH:  if (fetch_done) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (!op_halt) begin
          pc_d = taken ? PC_WIDTH'(tgt)
                       : pc_q + PC_WIDTH'(1);
        end
        unique case (1'b1)
          op_halt: state_d = S_HALT;
          op_alu:  state_d = S_WB;
          op_mem:  state_d = S_MEM;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_done) state_d = dmem_we_q ? S_FETCH : S_WB;
      end
      S_WB:    state_d = S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      wb_q       <= '0;
      z_q        <= 1'b0;
      n_q        <= 1'b0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dmem_we_q  <= 1'b0;
      daddr_q    <= '0;
      dwdata_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      // Registered so requests stay low the cycle after reset.
      imem_req_q <= (state_d == S_FETCH);
      dmem_req_q <= (state_d == S_MEM);
      if (fetch_done) ir_q <= imem_rdata;
      if (state_q == S_DECODE) begin
        a_q <= ra_val;
        b_q <= rb_val;
      end
      if (state_q == S_EXEC) begin
        wb_q <= alu_res;
        if (op_alu) begin
          z_q <= alu_z;
          n_q <= alu_n;
        end
        if (op_mem) begin
          daddr_q   <= ea;
          dwdata_q  <= b_q;
          dmem_we_q <= (op == OP_ST);
        end
      end
      if (mem_done) begin
        dmem_we_q <= 1'b0;
        if (!dmem_we_q) wb_q <= dmem_rdata;
      end
    end
  end

`ifdef MINIMICRO_MC_CARRY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q <= 1'b0;
    end else if (state_q == S_EXEC && op_alu) begin
      c_q <= alu_c;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (state_q == S_WB && rd_ok) begin
      rf_q[f_rd[RI_W-1:0]] <= wb_q;
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign dmem_req   = dmem_req_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_addr  = daddr_q;
  assign dmem_wdata = dwdata_q;
  assign halted     = (state_q == S_HALT);
  assign pc         = pc_q;

endmodule

// File: tb/tb_minimicro_mc.sv
// tb_minimicro_mc: directed program table plus handshake/reset sequences.
// Memories are modelled here with programmable ack delays.
module tb_minimicro_mc;

  localparam logic [3:0] ADD = 4'h1, SUB = 4'h2, AND_ = 4'h3;
  localparam logic [3:0] OR_ = 4'h4, ADDI = 4'h5, LD = 4'h6;
  localparam logic [3:0] ST = 4'h7, BR = 4'h8, HLT = 4'hF;

`ifdef MINIMICRO_MC_CARRY_EN
  localparam logic [7:0] CS_NEXT = 8'h60;
`else
  localparam logic [7:0] CS_NEXT = 8'h51;
`endif

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] ins;
    int          cyc;
    bit          st;
    logic [7:0]  sa;
    logic [15:0] sd;
    string       nm;
  } vec_t;

  logic        clk, rst_n;
  logic        imem_req, imem_ack;
  logic [7:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic        halted;
  logic [7:0]  pc;

  logic [15:0] imem [256];
  logic [15:0] dmem [256];
  bit  imem_auto, dmem_auto, force_iack, force_dack;
  int  dmem_wait;
  int  st_cnt;
  logic [7:0]  last_sa;
  logic [15:0] last_sd;
  int  n_chk, n_pass;
  int  dreq_n, dreq_bad;
  vec_t tab[$];

  minimicro_mc dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .halted     (halted),
    .pc         (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin : iresp
    imem_ack = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (imem_auto && imem_req) begin
        imem_ack = 1'b1;
        imem_rdata = imem[imem_addr];
      end else begin
        imem_ack = force_iack;
      end
    end
  end

  initial begin : dresp
    int cnt;
    cnt = 0;
    dmem_ack = 1'b0;
    dmem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      if (dmem_auto && dmem_req) begin
        if (cnt >= dmem_wait) begin
          dmem_ack = 1'b1;
          cnt = 0;
          if (dmem_we) begin
            dmem[dmem_addr] = dmem_wdata;
            st_cnt++;
            last_sa = dmem_addr;
            last_sd = dmem_wdata;
          end else begin
            dmem_rdata = dmem[dmem_addr];
          end
        end else begin
          dmem_ack = 1'b0;
          cnt++;
        end
      end else begin
        dmem_ack = force_dack;
        cnt = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic [7:0] a, input logic [15:0] i,
                              input int c, input bit s,
                              input logic [7:0] sa,
                              input logic [15:0] sd,
                              input string nm);
    vec_t v;
    v.addr = a; v.ins = i; v.cyc = c; v.st = s;
    v.sa = sa; v.sd = sd; v.nm = nm;
    return v;
  endfunction

  function automatic logic [15:0] ri(input logic [3:0] op,
                                     input logic [3:0] rd,
                                     input logic [3:0] rs1,
                                     input logic [3:0] hi);
    return {op, hi, rs1, rd};
  endfunction

  function automatic logic [15:0] bi(input logic [3:0] cnd,
                                     input logic [7:0] t);
    return {BR, cnd, t};
  endfunction

  // Called at a negedge in the fetch cycle of v; returns at the next fetch.
  task automatic step(input vec_t v);
    int cyc;
    int st0;
    bit low;
    logic [24:0] first;
    chk({v.nm, " pc"}, 32'(imem_addr), 32'(v.addr));
    st0 = st_cnt;
    cyc = 0;
    low = 0;
    dreq_n = 0;
    dreq_bad = 0;
    first = '0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (dmem_req) begin
        if (dreq_n == 0) first = {dmem_we, dmem_addr, dmem_wdata};
        else if ({dmem_we, dmem_addr, dmem_wdata} !== first) dreq_bad++;
        dreq_n++;
      end
      if (!imem_req) low = 1;
      else if (low) break;
    end
    chk({v.nm, " cyc"}, 32'(cyc), 32'(v.cyc));
    if (v.st)
      chk({v.nm, " st"}, {8'(st_cnt - st0), last_sa, last_sd},
          {8'd1, v.sa, v.sd});
  endtask

  initial begin
    int bad;
    n_chk = 0; n_pass = 0;
    rst_n = 1'b0;
    imem_auto = 1; dmem_auto = 1;
    force_iack = 0; force_dack = 0;
    dmem_wait = 0; st_cnt = 0;
    last_sa = '0; last_sd = '0;
    for (int i = 0; i < 256; i++) begin
      imem[i] = 16'h0000;
      dmem[i] = 16'h0000;
    end

    tab.push_back(mk(8'h00, ri(ADDI, 1, 0, 5), 4, 0, 0, 0, "addi r1"));
    tab.push_back(mk(8'h01, ri(ADDI, 2, 0, 3), 4, 0, 0, 0, "addi r2"));
    tab.push_back(mk(8'h02, ri(SUB, 3, 1, 2), 4, 0, 0, 0, "sub r3"));
    tab.push_back(mk(8'h03, ri(ST, 3, 0, 0), 4, 1, 8'h00, 16'h0002,
                     "st r3"));
    tab.push_back(mk(8'h04, bi(4'h1, 8'h40), 3, 0, 0, 0, "beq nt"));
    tab.push_back(mk(8'h05, bi(4'h3, 8'h40), 3, 0, 0, 0, "bmi nt"));
    tab.push_back(mk(8'h06, ri(SUB, 4, 2, 1), 4, 0, 0, 0, "sub r4"));
    tab.push_back(mk(8'h07, ri(ST, 4, 0, 1), 4, 1, 8'h01, 16'hFFFE,
                     "st r4"));
    tab.push_back(mk(8'h08, bi(4'h3, 8'h20), 3, 0, 0, 0, "bmi t"));
    tab.push_back(mk(8'h20, bi(4'h2, 8'h30), 3, 0, 0, 0, "bne t"));
    tab.push_back(mk(8'h30, ri(AND_, 5, 1, 2), 4, 0, 0, 0, "and"));
    tab.push_back(mk(8'h31, ri(OR_, 6, 1, 2), 4, 0, 0, 0, "or"));
    tab.push_back(mk(8'h32, ri(ST, 5, 1, 4), 4, 1, 8'h09, 16'h0001,
                     "st and"));
    tab.push_back(mk(8'h33, ri(ST, 6, 2, 15), 4, 1, 8'h12, 16'h0007,
                     "st or"));
    tab.push_back(mk(8'h34, ri(SUB, 7, 1, 1), 4, 0, 0, 0, "sub zero"));
    tab.push_back(mk(8'h35, bi(4'h1, 8'h40), 3, 0, 0, 0, "beq t"));
    tab.push_back(mk(8'h40, bi(4'h4, 8'h42), 3, 0, 0, 0, "bpl t"));
    tab.push_back(mk(8'h42, bi(4'h7, 8'h50), 3, 0, 0, 0, "bc7 nt"));
    tab.push_back(mk(8'h43, ri(LD, 8, 0, 1), 5, 0, 0, 0, "ld r8"));
    tab.push_back(mk(8'h44, ri(ST, 8, 0, 2), 4, 1, 8'h02, 16'hFFFE,
                     "st r8"));
    tab.push_back(mk(8'h45, ri(ADDI, 10, 4, 1), 4, 0, 0, 0, "addi ffff"));
    tab.push_back(mk(8'h46, bi(4'h5, 8'h70), 3, 0, 0, 0, "bcs nt"));
    tab.push_back(mk(8'h47, ri(ADDI, 11, 0, 1), 4, 0, 0, 0, "addi r11"));
    tab.push_back(mk(8'h48, ri(ADD, 12, 10, 11), 4, 0, 0, 0, "add wrap"));
    tab.push_back(mk(8'h49, ri(ST, 12, 0, 3), 4, 1, 8'h03, 16'h0000,
                     "st wrap"));
    tab.push_back(mk(8'h4A, bi(4'h1, 8'h50), 3, 0, 0, 0, "beq wrap"));
    tab.push_back(mk(8'h50, bi(4'h5, 8'h60), 3, 0, 0, 0, "bcs"));
    tab.push_back(mk(CS_NEXT, bi(4'h0, 8'hFF), 3, 0, 0, 0, "bal ff"));
    tab.push_back(mk(8'hFF, 16'hA123, 3, 0, 0, 0, "nop ff"));
    foreach (tab[i]) imem[tab[i].addr] = tab[i].ins;
    imem[8'h51] = bi(4'h0, 8'hFF);
    imem[8'h60] = bi(4'h0, 8'hFF);

    repeat (3) @(negedge clk);
    chk("rst imem_req", 32'(imem_req), 32'd0);
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst dmem_we", 32'(dmem_we), 32'd0);
    chk("rst halted", 32'(halted), 32'd0);
    chk("rst pc", 32'(pc), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req after rst", 32'(imem_req), 32'd1);

    foreach (tab[i]) step(tab[i]);
    chk("wrap pc", 32'(imem_addr), 32'h00);

    // Reset while a fetch is waiting for its ack.
    imem_auto = 0;
    repeat (2) @(negedge clk);
    chk("fwait req", 32'(imem_req), 32'd1);
    rst_n = 1'b0;
    force_iack = 1;
    @(negedge clk);
    chk("frst reqs", {30'd0, imem_req, dmem_req}, 32'd0);
    chk("frst pc", 32'(pc), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    force_iack = 0;
    chk("frst late ack", {23'd0, imem_req, imem_addr}, 32'h100);

    // Delayed store ack, load back, then HALT.
    imem[0] = ri(ADDI, 1, 0, 5);
    imem[1] = ri(ST, 1, 0, 4);
    imem[2] = ri(LD, 5, 0, 4);
    imem[3] = ri(ST, 5, 0, 5);
    imem[4] = {HLT, 12'h000};
    dmem[4] = '0;
    dmem[5] = '0;
    imem_auto = 1;
    dmem_wait = 3;
    step(mk(8'h00, imem[0], 4, 0, 0, 0, "s addi"));
    step(mk(8'h01, imem[1], 7, 1, 8'h04, 16'h0005, "s st wait"));
    chk("st req cycles", 32'(dreq_n), 32'd4);
    chk("st stable", 32'(dreq_bad), 32'd0);
    dmem_wait = 0;
    step(mk(8'h02, imem[2], 5, 0, 0, 0, "s ld"));
    step(mk(8'h03, imem[3], 4, 1, 8'h05, 16'h0005, "s st r5"));
    chk("halt pc", 32'(imem_addr), 32'h04);
    for (int i = 0; i < 10 && !halted; i++) @(negedge clk);
    chk("halted", 32'(halted), 32'd1);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || dmem_req || !halted) bad++;
    end
    chk("halt quiet", 32'(bad), 32'd0);
    chk("halt pc hold", 32'(pc), 32'h04);

    // Reset while a store is waiting for its ack.
    imem[0] = ri(ST, 0, 0, 7);
    dmem_auto = 0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("hrst halted", 32'(halted), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10 && !dmem_req; i++) @(negedge clk);
    chk("mwait req", {22'd0, dmem_req, dmem_we, dmem_addr}, 32'h307);
    repeat (2) @(negedge clk);
    chk("mwait hold", 32'(dmem_req), 32'd1);
    rst_n = 1'b0;
    force_dack = 1;
    @(negedge clk);
    chk("mrst", {29'd0, imem_req, dmem_req, dmem_we}, 32'd0);
    chk("mrst pc", 32'(pc), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    force_dack = 0;
    chk("mrst late ack", {30'd0, imem_req, dmem_req}, 32'd2);
    dmem_auto = 1;
    step(mk(8'h00, imem[0], 4, 1, 8'h07, 16'h0000, "m st again"));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
